// File: rtl/iic_m_phy_seq.sv
// iic_m_phy_seq: I2C master bit-sequencer PHY.
//
// Plays STEP_NUM SCK/SDA steps per bit word, paced by a baud divider. It handles
// slave clock stretching with an optional timeout, checks for arbitration loss and
// returns a majority-voted receive bit for each word.
//
// Ports:
//   clk_sys, rst_n          clock, synchronous active-low reset
//   cfg_baud_div            step period minus 1 (cycles), cfg_sto stretch timeout (0 = off)
//   bit_wvalid/bit_wready   bit word handshake; bit_wdata = {sda_t[S], sck_o[S], sda_o[S]}
//                           with step k at bit S-1-k of each field
//   bit_rdata/bit_rvalid    voted receive bit, pulsed with bit_wready
//   iic_sck_i, iic_sda_i    pad inputs
//   iic_sck_o/_t, iic_sda_o/_t  pad drive (_t=1 drives)
//   err_arb, err_sto        arbitration-loss / stretch-timeout pulses
//   busy                    FSM not idle
//
// Build option: define IIC_M_PHY_ARB_EN to enable the arbitration check and err_arb.
// U_DLY is kept for interface compatibility; assignments carry no delay.

module iic_m_phy_seq #(
  parameter int unsigned U_DLY      = 1,
  parameter int unsigned STEP_NUM   = 4,
  parameter int unsigned BAUD_DIV_W = 16,
  parameter int unsigned STO_W      = 16
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic [BAUD_DIV_W-1:0]   cfg_baud_div,
  input  logic [STO_W-1:0]        cfg_sto,
  input  logic                    bit_wvalid,
  output logic                    bit_wready,
  input  logic [3*STEP_NUM-1:0]   bit_wdata,
  output logic                    bit_rdata,
  output logic                    bit_rvalid,
  input  logic                    iic_sck_i,
  input  logic                    iic_sda_i,
  output logic                    iic_sck_o,
  output logic                    iic_sck_t,
  output logic                    iic_sda_o,
  output logic                    iic_sda_t,
  output logic                    err_arb,
  output logic                    err_sto,
  output logic                    busy
);

  localparam int unsigned StepW = (STEP_NUM > 1) ? $clog2(STEP_NUM) : 1;
  localparam int unsigned CntW  = $clog2(STEP_NUM + 1);
  localparam logic [StepW-1:0] LastStep = StepW'(STEP_NUM - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StStretch, StAbort} state_e;

  state_e                state_q, state_d;
  logic [BAUD_DIV_W-1:0] baud_q, baud_d;
  logic [StepW-1:0]      step_q, step_d;
  logic [STO_W-1:0]      sto_q, sto_d;
  logic [CntW-1:0]       n_q, n_d, m_q, m_d;
  logic                  sck_o_q, sck_o_d, sck_t_q, sck_t_d;
  logic                  sda_o_q, sda_o_d, sda_t_q, sda_t_d;
  logic                  wready_q, wready_d, rvalid_q, rvalid_d, rdata_q, rdata_d;
  logic                  err_arb_q, err_arb_d, err_sto_q, err_sto_d;

  logic                  unused_dly;
  assign unused_dly = (U_DLY != 0);

  // Per-step fields of the word, and the step selected by step_q.
  logic [STEP_NUM-1:0] fld_t, fld_c, fld_d;
  logic [StepW-1:0]    bit_idx;
  logic                tick, stretch_hit, arb_hit, smp_hit;

  assign fld_t   = bit_wdata[3*STEP_NUM-1:2*STEP_NUM];
  assign fld_c   = bit_wdata[2*STEP_NUM-1:STEP_NUM];
  assign fld_d   = bit_wdata[STEP_NUM-1:0];
  assign bit_idx = LastStep - step_q;

  assign tick = (state_q == StDrive) && (baud_q >= cfg_baud_div);

  // Checks look at the step currently on the pads, i.e. the one being left at this tick.
  assign stretch_hit = sck_t_q & sck_o_q & ~iic_sck_i;
`ifdef IIC_M_PHY_ARB_EN
  assign arb_hit = sda_t_q & sda_o_q & sck_o_q & ~iic_sda_i;
`else
  assign arb_hit = 1'b0;
`endif
  assign smp_hit = ~sda_t_q & sck_o_q & iic_sck_i;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    step_d    = step_q;
    sto_d     = sto_q;
    n_d       = n_q;
    m_d       = m_q;
    sck_o_d   = sck_o_q;
    sck_t_d   = sck_t_q;
    sda_o_d   = sda_o_q;
    sda_t_d   = sda_t_q;
    wready_d  = 1'b0;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    err_arb_d = 1'b0;
    err_sto_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bit_wvalid) begin
          state_d = StDrive;
          baud_d  = '0;
          step_d  = '0;
        end
      end

      StDrive: begin
        if (!tick) begin
          baud_d = baud_q + BAUD_DIV_W'(1);
        end else begin
          baud_d = '0;
          if (stretch_hit) begin
            state_d = StStretch;
            sto_d   = '0;
          end else if (arb_hit) begin
            state_d   = StAbort;
            err_arb_d = 1'b1;
          end else if ((step_q == '0) && !bit_wvalid) begin
            // No follow-on word after a consumed one: release and go idle.
            state_d = StIdle;
            sck_o_d = 1'b1;
            sck_t_d = 1'b0;
            sda_o_d = 1'b1;
            sda_t_d = 1'b0;
          end else begin
            sck_o_d = fld_c[bit_idx];
            sck_t_d = 1'b1;
            sda_o_d = fld_d[bit_idx];
            sda_t_d = fld_t[bit_idx];
            // Step 0 starts a word: whatever was on the pads belongs to the previous one.
            if (step_q == '0) begin
              n_d = '0;
              m_d = '0;
            end else begin
              n_d = n_q + CntW'(smp_hit);
              m_d = m_q + CntW'(smp_hit & iic_sda_i);
            end
            if (step_q == LastStep) begin
              step_d   = '0;
              wready_d = 1'b1;
              if (n_d != '0) begin
                rvalid_d = 1'b1;
                // Tie votes 1, like the pulled-up bus.
                rdata_d  = ({m_d, 1'b0} >= {1'b0, n_d});
              end
            end else begin
              step_d = step_q + StepW'(1);
            end
          end
        end
      end

      StStretch: begin
        sto_d = sto_q + STO_W'(1);
        if (iic_sck_i) begin
          state_d = StDrive;
          baud_d  = '0;
        end else if ((cfg_sto != '0) && (sto_d >= cfg_sto)) begin
          state_d   = StAbort;
          err_sto_d = 1'b1;
        end
      end

      StAbort: begin
        sck_o_d = 1'b1;
        sck_t_d = 1'b0;
        sda_o_d = 1'b1;
        sda_t_d = 1'b0;
        if (!bit_wvalid) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      step_q    <= '0;
      sto_q     <= '0;
      n_q       <= '0;
      m_q       <= '0;
      sck_o_q   <= 1'b1;
      sck_t_q   <= 1'b0;
      sda_o_q   <= 1'b1;
      sda_t_q   <= 1'b0;
      wready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 1'b0;
      err_arb_q <= 1'b0;
      err_sto_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      step_q    <= step_d;
      sto_q     <= sto_d;
      n_q       <= n_d;
      m_q       <= m_d;
      sck_o_q   <= sck_o_d;
      sck_t_q   <= sck_t_d;
      sda_o_q   <= sda_o_d;
      sda_t_q   <= sda_t_d;
      wready_q  <= wready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_arb_q <= err_arb_d;
      err_sto_q <= err_sto_d;
    end
  end

  assign iic_sck_o  = sck_o_q;
  assign iic_sck_t  = sck_t_q;
  assign iic_sda_o  = sda_o_q;
  assign iic_sda_t  = sda_t_q;
  assign bit_wready = wready_q;
  assign bit_rvalid = rvalid_q;
  assign bit_rdata  = rdata_q;
  assign err_arb    = err_arb_q;
  assign err_sto    = err_sto_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_iic_m_phy_seq.sv
// Testbench for iic_m_phy_seq (STEP_NUM=4). Expected pad levels, handshakes and the
// voted bit come from step timing arithmetic (tick n lands (div+1)*n edges after start)
// and the word/slave tables held here.

module tb_iic_m_phy_seq;

  localparam int S = 4;
  localparam logic [3:0] REL = 4'b1010;  // {sck_o, sck_t, sda_o, sda_t} released

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_baud_div, cfg_sto;
  logic        bit_wvalid, bit_wready;
  logic [11:0] bit_wdata;
  logic        bit_rdata, bit_rvalid;
  logic        iic_sck_i, iic_sda_i;
  logic        iic_sck_o, iic_sck_t, iic_sda_o, iic_sda_t;
  logic        err_arb, err_sto, busy;
  logic [3:0]  pads;

  // Slave/bus model: open-drain wired with slave clock hold and slave SDA level.
  logic sck_hold, slave_sda;
  assign iic_sck_i = (iic_sck_t ? iic_sck_o : 1'b1) & ~sck_hold;
  assign iic_sda_i = (iic_sda_t ? iic_sda_o : 1'b1) & slave_sda;
  assign pads = {iic_sck_o, iic_sck_t, iic_sda_o, iic_sda_t};

  iic_m_phy_seq dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .cfg_baud_div (cfg_baud_div),
    .cfg_sto      (cfg_sto),
    .bit_wvalid   (bit_wvalid),
    .bit_wready   (bit_wready),
    .bit_wdata    (bit_wdata),
    .bit_rdata    (bit_rdata),
    .bit_rvalid   (bit_rvalid),
    .iic_sck_i    (iic_sck_i),
    .iic_sda_i    (iic_sda_i),
    .iic_sck_o    (iic_sck_o),
    .iic_sck_t    (iic_sck_t),
    .iic_sda_o    (iic_sda_o),
    .iic_sda_t    (iic_sda_t),
    .err_arb      (err_arb),
    .err_sto      (err_sto),
    .busy         (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_err = 0;
  int err_arb_seen = 0;
  int err_sto_seen = 0;
  logic rdata_exp;
  logic [11:0] words [4];
  logic [3:0]  rbits [4];  // slave SDA per step (bit k = step k) when master releases SDA

  always @(negedge clk_sys) begin
    if (err_arb) err_arb_seen++;
    if (err_sto) err_sto_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] pad_of(input logic [11:0] w, input int k);
    logic [3:0] tf, cf, df;
    tf = w[11:8];
    cf = w[7:4];
    df = w[3:0];
    return {cf[S-1-k], 1'b1, df[S-1-k], tf[S-1-k]};
  endfunction

  // A step is read while it is held with SDA released and SCK high; the last step is
  // still on the pads when the word is consumed, so only steps 0..S-2 count.
  function automatic void vote(input logic [11:0] w, input logic [3:0] rb,
                               output int n, output int m);
    n = 0;
    m = 0;
    for (int k = 0; k < S - 1; k++) begin
      if (!w[8+S-1-k] && w[4+S-1-k]) begin
        n++;
        m += int'(rb[k]);
      end
    end
  endfunction

  task automatic run_seq(input int nw, input int div);
    int p, ticks, j, k, n, m, hs;
    logic [3:0] exp_pad;
    logic on, exp_rdy, exp_rv;
    p = div + 1;
    cfg_baud_div = 16'(div);
    cfg_sto = '0;
    bit_wdata = words[0];
    bit_wvalid = 1'b1;
    slave_sda = 1'b1;
    for (int e = 0; e <= (nw * S + 1) * p + 1; e++) begin
      @(negedge clk_sys);
      ticks = e / p;
      on = (e > 0) && (e % p == 0);
      exp_pad = REL;
      if (ticks >= 1 && ticks <= nw * S) exp_pad = pad_of(words[(ticks-1)/S], (ticks-1) % S);
      check("pad", 32'(pads), 32'(exp_pad));
      check("busy", 32'(busy), 32'(ticks <= nw * S));
      exp_rdy = on && (ticks % S == 0) && (ticks <= nw * S);
      exp_rv = 1'b0;
      if (exp_rdy) begin
        vote(words[ticks/S-1], rbits[ticks/S-1], n, m);
        if (n > 0) begin
          exp_rv = 1'b1;
          rdata_exp = (2 * m >= n);
        end
      end
      check("wready", 32'(bit_wready), 32'(exp_rdy));
      check("rvalid", 32'(bit_rvalid), 32'(exp_rv));
      check("rdata", 32'(bit_rdata), 32'(rdata_exp));
      // Handshake completed at the edge just passed: present the next word or drop valid.
      if (e >= 1 && (e - 1) % p == 0) begin
        hs = (e - 1) / p;
        if (hs >= S && hs % S == 0 && hs <= nw * S) begin
          if (hs / S < nw) bit_wdata = words[hs/S];
          else bit_wvalid = 1'b0;
        end
      end
      if (on && ticks <= nw * S) begin
        j = (ticks - 1) / S;
        k = (ticks - 1) % S;
        slave_sda = words[j][8+S-1-k] ? 1'b1 : rbits[j][k];
      end
    end
    slave_sda = 1'b1;
  endtask

  task automatic run_stretch(input int sto, input int hold);
    logic [11:0] w;
    int a0, a1;
    w = 12'hFC6;
    cfg_baud_div = 16'd2;
    cfg_sto = 16'(sto);
    bit_wdata = w;
    bit_wvalid = 1'b1;
    a0 = err_arb_seen;
    a1 = err_sto_seen;
    repeat (4) @(negedge clk_sys);
    check("st_step0", 32'(pads), 32'(pad_of(w, 0)));
    sck_hold = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("st_enter", 32'(pads), 32'(pad_of(w, 0)));
    if (sto == 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_sys);
        check("st_hold", 32'({busy, pads}), 32'({1'b1, pad_of(w, 0)}));
      end
      sck_hold = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("st_wait", 32'(pads), 32'(pad_of(w, 0)));
      @(negedge clk_sys);
      check("st_resume", 32'(pads), 32'(pad_of(w, 1)));
      repeat (6) @(negedge clk_sys);
      check("st_step3", 32'(pads), 32'(pad_of(w, 3)));
      check("st_rdy", 32'({bit_wready, bit_rvalid}), 32'b10);
      @(negedge clk_sys);
      bit_wvalid = 1'b0;
      repeat (2) @(negedge clk_sys);
      check("st_rel", 32'({busy, pads}), 32'({1'b0, REL}));
      check("st_noerr", 32'((err_sto_seen - a1) + (err_arb_seen - a0)), 32'd0);
    end else begin
      for (int i = 1; i < sto; i++) begin
        @(negedge clk_sys);
        check("sto_quiet", 32'(err_sto), 32'd0);
      end
      @(negedge clk_sys);
      check("sto_pulse", 32'(err_sto), 32'd1);
      check("sto_held", 32'(pads), 32'(pad_of(w, 0)));
      @(negedge clk_sys);
      check("sto_once", 32'(err_sto), 32'd0);
      check("sto_rel", 32'({busy, bit_wready, pads}), 32'({2'b10, REL}));
      @(negedge clk_sys);
      check("sto_abort", 32'({busy, bit_wready, pads}), 32'({2'b10, REL}));
      bit_wvalid = 1'b0;
      sck_hold = 1'b0;
      @(negedge clk_sys);
      check("sto_idle", 32'(busy), 32'd0);
      check("sto_count", 32'(err_sto_seen - a1), 32'd1);
    end
    cfg_sto = '0;
  endtask

  task automatic run_arb();
    logic [11:0] w;
    int a0;
    w = 12'hFCF;
    cfg_baud_div = 16'd2;
    bit_wdata = w;
    bit_wvalid = 1'b1;
    a0 = err_arb_seen;
    repeat (4) @(negedge clk_sys);
    check("arb_step0", 32'(pads), 32'(pad_of(w, 0)));
    slave_sda = 1'b0;
    repeat (3) @(negedge clk_sys);
`ifdef IIC_M_PHY_ARB_EN
    check("arb_pulse", 32'(err_arb), 32'd1);
    check("arb_held", 32'(pads), 32'(pad_of(w, 0)));
    @(negedge clk_sys);
    check("arb_once", 32'(err_arb), 32'd0);
    check("arb_rel", 32'({busy, bit_wready, pads}), 32'({2'b10, REL}));
    bit_wvalid = 1'b0;
    slave_sda = 1'b1;
    @(negedge clk_sys);
    check("arb_idle", 32'(busy), 32'd0);
    check("arb_count", 32'(err_arb_seen - a0), 32'd1);
`else
    check("arb_off", 32'(err_arb), 32'd0);
    check("arb_step1", 32'(pads), 32'(pad_of(w, 1)));
    repeat (6) @(negedge clk_sys);
    check("arb_step3", 32'(pads), 32'(pad_of(w, 3)));
    check("arb_rdy", 32'({bit_wready, bit_rvalid}), 32'b10);
    @(negedge clk_sys);
    bit_wvalid = 1'b0;
    slave_sda = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("arb_done", 32'({busy, pads}), 32'({1'b0, REL}));
    check("arb_count", 32'(err_arb_seen - a0), 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cfg_baud_div = '0;
    cfg_sto = '0;
    bit_wvalid = 1'b0;
    bit_wdata = '0;
    sck_hold = 1'b0;
    slave_sda = 1'b1;
    rdata_exp = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_pads", 32'(pads), 32'(REL));
    check("rst_flags", 32'({busy, bit_wready, bit_rvalid, bit_rdata, err_arb, err_sto}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_sys);
    check("idle_busy", 32'(busy), 32'd0);

    // Plain write word, slave idle.
    words[0] = 12'hFC6;
    rbits[0] = 4'hF;
    run_seq(1, 3);
    // Reads: pattern 1,0 ties to 1, then 0,0 gives 0.
    words[0] = 12'h0CF;
    rbits[0] = 4'b0001;
    run_seq(1, 3);
    rbits[0] = 4'b0000;
    run_seq(1, 2);
    // Back-to-back random words.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) begin
        words[i] = 12'($urandom);
        rbits[i] = 4'($urandom);
      end
      run_seq(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
    end

    run_stretch(0, 20);
    run_stretch(10, 0);
    run_arb();

    // Leave rdata at 1, then reset in the middle of a word.
    words[0] = 12'h0CF;
    rbits[0] = 4'b0001;
    run_seq(1, 1);
    cfg_baud_div = 16'd2;
    bit_wdata = 12'hFC6;
    bit_wvalid = 1'b1;
    repeat (5) @(negedge clk_sys);
    rst_n = 1'b0;
    @(negedge clk_sys);
    rdata_exp = 1'b0;
    check("mid_rst_pads", 32'(pads), 32'(REL));
    check("mid_rst_flags", 32'({busy, bit_wready, bit_rvalid, bit_rdata}),
          32'({3'b000, rdata_exp}));
    bit_wvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk_sys);
    check("mid_rst_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
